// File: rtl/derandomizer_pkg.sv
// Shared constants for the burst randomizer/derandomizer pair: LFSR geometry, IV framing and
// FSM state encoding.
package derandomizer_pkg;

  localparam int unsigned LfsrW = 15;
  localparam int unsigned TapHi = 14;
  localparam int unsigned TapLo = 13;

  localparam logic [1:0] IvMid = 2'b11;
  localparam logic       IvOne = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDrain
  } state_e;

  function automatic logic [LfsrW-1:0] make_iv(input logic [3:0] bsid,
                                               input logic [3:0] uiuc,
                                               input logic [3:0] frame_num);
    return {bsid, IvMid, uiuc, IvOne, frame_num};
  endfunction

endpackage

// File: rtl/derand_lfsr.sv
// 1 + x^14 + x^15 keystream generator; loads an IV and steps once per accepted input bit.
module derand_lfsr
  import derandomizer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [LfsrW-1:0] i_iv,
  input  logic             i_adv,
  output logic             o_ks
);

  logic [LfsrW-1:0] r_lfsr;

  assign o_ks = r_lfsr[TapHi] ^ r_lfsr[TapLo];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr <= '0;
    end else if (i_load) begin
      r_lfsr <= i_iv;
    end else if (i_adv) begin
      r_lfsr <= {r_lfsr[LfsrW-2:0], o_ks};
    end
  end

endmodule

// File: rtl/derandomizer.sv
// Burst derandomizer: XORs the received bit stream with the LFSR keystream seeded from the IV,
// through a single-entry output register with ready/valid on both sides.
module derandomizer
  import derandomizer_pkg::*;
#(
  parameter int unsigned BURST_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [3:0]         bsid,
  input  logic [3:0]         uiuc,
  input  logic [3:0]         frame_num,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               in_bit,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done
);

  state_e             r_state;
  logic [LfsrW-1:0]   r_iv;
  logic [BURST_W-1:0] r_len;
  logic [BURST_W-1:0] r_count;
  logic               r_out_bit;
  logic               r_out_valid;
  logic               r_done;
  logic               w_in_xfer;
  logic               w_ks;

  // A full register still accepts when it is being popped in the same cycle.
  assign in_ready  = (r_state == StRun) && (!r_out_valid || out_ready);
  assign w_in_xfer = in_valid && in_ready;

  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != StIdle);
  assign done      = r_done;

  derand_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .i_load (r_state == StLoad),
    .i_iv   (r_iv),
    .i_adv  (w_in_xfer),
    .o_ks   (w_ks)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_iv        <= '0;
      r_len       <= '0;
      r_count     <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_out_bit   <= in_bit ^ w_ks;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          if (start) begin
            if (burst_len != '0) begin
              r_iv    <= make_iv(bsid, uiuc, frame_num);
              r_len   <= burst_len;
              r_state <= StLoad;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        StLoad: begin
          r_count <= r_len;
          r_state <= StRun;
        end
        StRun: begin
          if (w_in_xfer) begin
            r_count <= r_count - BURST_W'(1);
            if (r_count == BURST_W'(1)) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          // Finish on the cycle the last bit leaves the output register.
          if (!r_out_valid || out_ready) begin
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_derandomizer.sv
// Randomized scoreboard bench for derandomizer: a keystream reference built from the bit
// recurrence s[n+15] = s[n] ^ s[n+1] predicts every output bit.
module tb_derandomizer;

  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    bsid = '0;
  logic [3:0]    uiuc = '0;
  logic [3:0]    frame_num = '0;
  logic [BW-1:0] burst_len = '0;
  logic          in_bit = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_ready;
  logic          out_bit;
  logic          out_valid;
  logic          busy;
  logic          done;

  derandomizer #(.BURST_W(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bsid      (bsid),
    .uiuc      (uiuc),
    .frame_num (frame_num),
    .burst_len (burst_len),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  bit ks[0:299];
  bit g_in[0:255];
  bit g_exp[0:255];

  // Scoreboard: driver writes sb/sb_wr/sb_skip, monitor owns sb_rd.
  bit sb[0:1023];
  int sb_wr = 0;
  int sb_rd = 0;
  int sb_skip = 0;

  int pops = 0;
  int stall_trig = 0;
  int stall_at = -1;
  bit stall_test = 1'b0;
  bit rnd_ready = 1'b0;

  function automatic void gen_ks(input logic [3:0] b, input logic [3:0] u, input logic [3:0] f,
                                 input int n);
    logic [14:0] iv;
    bit seq[0:319];
    iv = {b, 2'b11, u, 1'b1, f};
    for (int i = 0; i < 15; i++) seq[i] = iv[14-i];
    for (int i = 0; i < n; i++) begin
      seq[i+15] = seq[i] ^ seq[i+1];
      ks[i] = seq[i+15];
    end
  endfunction

  function automatic void prep_random(input int n);
    bit m;
    for (int j = 0; j < n; j++) begin
      m = 1'($urandom_range(1));
      g_in[j]  = m ^ ks[j];
      g_exp[j] = m;
    end
  endfunction

  // Monitor: pops the scoreboard on each downstream transfer and checks hold behaviour.
  initial begin
    bit prev_hold;
    bit prev_bit;
    prev_hold = 1'b0;
    prev_bit  = 1'b0;
    forever begin
      @(negedge clk);
      if (sb_rd < sb_skip) sb_rd = sb_skip;
      if (reset) begin
        if (prev_hold) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_bit", int'(out_bit), int'(prev_bit));
        end
        if (out_valid && !out_ready) chk("in_ready_when_full", int'(in_ready), 0);
        if (out_valid && out_ready) begin
          if (sb_rd >= sb_wr) begin
            chk("unexpected_out_valid", int'(out_valid), 0);
          end else begin
            chk($sformatf("out_bit[%0d]", sb_rd), int'(out_bit), int'(sb[sb_rd]));
            sb_rd++;
          end
          pops++;
          if (stall_test && pops == stall_at) stall_trig++;
        end
        prev_hold = out_valid && !out_ready;
        prev_bit  = out_bit;
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  // Downstream ready driver.
  initial begin
    int cnt;
    int last;
    cnt  = 0;
    last = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_trig != last) begin
        last = stall_trig;
        cnt  = 3;
      end
      if (cnt > 0) begin
        out_ready = 1'b0;
        cnt--;
      end else if (rnd_ready) begin
        out_ready = ($urandom_range(3) != 0);
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  task automatic start_burst(input logic [3:0] b, input logic [3:0] u, input logic [3:0] f,
                             input int len);
    @(posedge clk);
    #1;
    bsid      = b;
    uiuc      = u;
    frame_num = f;
    burst_len = BW'(len);
    start     = 1'b1;
  endtask

  task automatic feed(input int n, input bit rnd_valid, input int mid_start_at,
                      input int stop_at);
    int j;
    int wd;
    bit did_mid;
    j = 0;
    wd = 0;
    did_mid = 1'b0;
    while (j < n && j != stop_at) begin
      @(posedge clk);
      #1;
      start    = 1'b0;
      in_valid = rnd_valid ? 1'($urandom_range(1)) : 1'b1;
      in_bit   = in_valid ? g_in[j] : 1'($urandom_range(1));
      if (!did_mid && j == mid_start_at) begin
        start     = 1'b1;
        burst_len = BW'(7);
        bsid      = ~bsid;
        did_mid   = 1'b1;
      end
      @(negedge clk);
      if (wd == 0) begin
        chk("busy_in_load", int'(busy), 1);
        chk("in_ready_in_load", int'(in_ready), 0);
      end
      if (in_valid && in_ready) begin
        sb[sb_wr] = g_exp[j];
        sb_wr++;
        j++;
      end
      wd++;
      if (wd > 3000) begin
        chk("feed_timeout", j, n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit prev;
    bit got;
    prev = 1'b0;
    got  = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        chk({name, "_valid_before_done"}, int'(prev), 1);
        chk({name, "_valid_at_done"}, int'(out_valid), 0);
        chk({name, "_busy_at_done"}, int'(busy), 0);
        break;
      end
      prev = out_valid;
    end
    if (!got) chk({name, "_done_timeout"}, int'(done), 1);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, int'(done), 0);
    chk({name, "_in_ready_idle"}, int'(in_ready), 0);
    chk({name, "_scoreboard_drained"}, sb_wr - sb_rd, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit c5[0:4];
    int dcnt;
    c5 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    #12;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_bit", int'(out_bit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Known-answer burst with zero input
    for (int j = 0; j < 5; j++) begin
      g_in[j]  = 1'b0;
      g_exp[j] = c5[j];
    end
    start_burst(4'hA, 4'h5, 4'h3, 5);
    feed(5, 1'b0, -1, -1);
    wait_done("kat");

    // Same burst with downstream stall after the second output
    stall_at   = pops + 2;
    stall_test = 1'b1;
    start_burst(4'hA, 4'h5, 4'h3, 5);
    feed(5, 1'b0, -1, -1);
    wait_done("stall");
    stall_test = 1'b0;

    // 200-bit random message round trip with random downstream ready
    gen_ks(4'h6, 4'h9, 4'hE, 200);
    prep_random(200);
    rnd_ready = 1'b1;
    start_burst(4'h6, 4'h9, 4'hE, 200);
    feed(200, 1'b0, -1, -1);
    wait_done("msg200");
    rnd_ready = 1'b0;

    // 64-bit burst with gappy input valid
    gen_ks(4'h1, 4'hF, 4'h0, 64);
    prep_random(64);
    start_burst(4'h1, 4'hF, 4'h0, 64);
    feed(64, 1'b1, -1, -1);
    wait_done("gappy64");

    // Zero-length burst
    start_burst(4'h2, 4'h2, 4'h2, 0);
    @(posedge clk);
    #1;
    start = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      chk("len0_busy", int'(busy), 0);
      chk("len0_out_valid", int'(out_valid), 0);
    end
    chk("len0_done_pulses", dcnt, 1);

    // Start asserted mid-burst is ignored
    gen_ks(4'h3, 4'hC, 4'h7, 20);
    prep_random(20);
    start_burst(4'h3, 4'hC, 4'h7, 20);
    feed(20, 1'b0, 3, -1);
    wait_done("midstart");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midstart_no_restart", int'(busy), 0);
    end

    // Reset halfway through a burst, then a fresh burst with a new IV
    gen_ks(4'h8, 4'h4, 4'hB, 20);
    prep_random(20);
    start_burst(4'h8, 4'h4, 4'hB, 20);
    feed(20, 1'b0, -1, 10);
    reset = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_bit", int'(out_bit), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    sb_skip = sb_wr;
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("postrst_no_leftover", int'(out_valid), 0);
      chk("postrst_idle", int'(busy), 0);
    end
    gen_ks(4'h5, 4'hA, 4'h1, 20);
    prep_random(20);
    start_burst(4'h5, 4'hA, 4'h1, 20);
    feed(20, 1'b0, -1, -1);
    wait_done("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
